mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the datapath's MFA/MFC memory handshake. It holds a 256-byte big-endian memory and accepts a request when MFA is asserted. It then executes the SPARC load or store selected by a 6-bit op3 opcode after a programmable wait, and answers with MFC. It is the clocked replacement for the behavioural RAM: the datapath drives MAR[7:0], MDR, the MOP mux output and MFA, and this block returns DataOut and MFC.

## Interface
- WAIT_CYCLES, default 2: idle cycles inserted between request capture and access execution; legal range 0–15.
- Clk  input  1  rising-edge clock.
- Rst  input  1  reset, synchronous, active-high.
- MFA  input  1  memory function active; a request is level-held until MFC is seen.
- Opcode  input  6  SPARC op3 value:
  - Loads: 0x00/0x08 LD word, 0x01 LDUB, 0x02 LDUH, 0x09 LDSB, 0x0A LDSH.
  - Stores: 0x04 ST word, 0x05 STB, 0x06 STH.
- Address  input  8  byte address (MAR[7:0]).
- DataIn  input  32  store data (MDR); bytes and halfwords are taken from the low bits.
- DataOut  output  32  load result, zero- or sign-extended.
- MFC  output  1  memory function complete.
- Err  output  1  request rejected; valid while MFC=1.

## Operation
- Storage: 256 × 8 bits, big-endian. Word bytes at A..A+3 map to DataOut[31:24]..[7:0]; halfword bytes at A..A+1 map to [15:8],[7:0]. Rst does not clear the storage.
- FSM states:
  - IDLE: MFC=0. If MFA=1, latch Opcode, Address, DataIn and Cnt←WAIT_CYCLES, then go to BUSY.
  - BUSY: if Cnt≠0, decrement it. If Cnt=0, execute the latched request, set MFC←1 and Err as decided, then go to DONE.
  - DONE: MFC=1. When MFA=0, clear MFC and Err and go to IDLE.
- Inputs are ignored outside IDLE capture. Changing Opcode/Address/DataIn while in BUSY has no effect.
- Four-phase handshake: a new request requires MFA to drop after MFC rises. MFA held high in DONE does not start a second access.
- Loads: update DataOut.
  - LDUB/LDUH zero-extend to 32 bits.
  - LDSB/LDSH replicate bit 7 or bit 15 respectively.
  - LD returns the full word.
- Stores: write 1, 2 or 4 bytes from DataIn[7:0], [15:0] or [31:0]. DataOut holds its previous value.
- Undefined opcode: no access, DataOut held, Err=1, MFC still asserted.
- Reset values: MFC=0, Err=0, DataOut=32'h0, state IDLE, Cnt=0.
- Rst in BUSY or DONE aborts the request: no write occurs and MFC=0 on the next cycle. Rst has priority over MFA in the same cycle.

## Timing
- MFA=1 sampled in IDLE at edge E0. MFC rises at edge E0+WAIT_CYCLES+1. With WAIT_CYCLES=0, MFC rises one cycle after capture.
- DataOut is valid in the same cycle MFC rises and stays stable until the next load completes.
- A store is visible to any load captured at or after the edge where MFC rises.
- MFA=0 sampled in DONE at edge E1 gives MFC=0 and Err=0 after E1. IDLE can capture a new request at E1+1 at the earliest.
- Minimum request-to-request period is WAIT_CYCLES+3 cycles.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - Word access with Address[1:0]≠0, or halfword access with Address[0]≠0, performs no access.
  - Err=1, DataOut held, MFC completes with normal latency.
- MEM_ALIGN_CHECK_EN undefined:
  - The address is force-aligned down (word: Address & 8'hFC; halfword: Address & 8'hFE), the access executes, and Err=0.
  - Err is then raised only for undefined opcodes.

## Test plan
- WAIT_CYCLES=2; ST 0x04, Address 0x00, DataIn 0x9C044012; then LD 0x08, Address 0x00 -> DataOut=0x9C044012; MFC rises exactly 3 edges after MFA is sampled each time; Err=0.
- Following that store: LDSB 0x09 at 0x00 -> 0xFFFFFF9C; LDUB 0x01 at 0x00 -> 0x0000009C; LDUH 0x02 at 0x02 -> 0x00004012; LDSH 0x0A at 0x00 -> 0xFFFF9C04.
- STB 0x05, Address 0x01, DataIn 0x123456AB; then LD at 0x00 -> 0x9CAB4012. STH 0x06 at 0xFE with 0xBEEF; then LD at 0xFC -> low half 0xBEEF.
- With MEM_ALIGN_CHECK_EN: LD at 0x02 -> MFC=1, Err=1, DataOut unchanged. Without the macro: the same request returns the word at 0x00 with Err=0.
- MFA held high through DONE -> exactly one access and MFC stays 1. Dropping MFA -> MFC=0 next edge; re-raising MFA starts a fresh request.
- ST 0x55AA55AA to 0x10, with Rst pulsed while in BUSY -> MFC never rises; DataOut=0; a later LD at 0x10 returns the pre-existing contents. Undefined opcode 0x3F -> Err=1, no memory change.

Source files
------------

// File: rtl/mem_responder.sv
// Clocked 256-byte big-endian memory answering the MFA/MFC handshake with SPARC loads/stores.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned word/halfword accesses instead of force-aligning them.
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MFA,
  input  logic [5:0]  Opcode,
  input  logic [7:0]  Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_r, state_nxt_s;
  logic [5:0]  op_r;
  logic [7:0]  addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [31:0] dout_r, dout_nxt_s;
  logic        mfc_r, mfc_nxt_s;
  logic        err_r, err_nxt_s;
  logic        capture_s, we_s;
  logic [7:0]  mem_r [0:255];

  logic [1:0]  size_s;
  logic        is_load_s, signed_s, legal_s, ok_s;
  logic [7:0]  a0_s, a1_s, a2_s, a3_s;
  logic [31:0] load_val_s;

  // Opcode decode of the latched request
  always_comb begin
    size_s    = SZ_BYTE;
    is_load_s = 1'b0;
    signed_s  = 1'b0;
    legal_s   = 1'b1;
    case (op_r)
      6'h00, 6'h08: begin size_s = SZ_WORD; is_load_s = 1'b1; end
      6'h01:        begin size_s = SZ_BYTE; is_load_s = 1'b1; end
      6'h02:        begin size_s = SZ_HALF; is_load_s = 1'b1; end
      6'h09:        begin size_s = SZ_BYTE; is_load_s = 1'b1; signed_s = 1'b1; end
      6'h0A:        begin size_s = SZ_HALF; is_load_s = 1'b1; signed_s = 1'b1; end
      6'h04:        size_s = SZ_WORD;
      6'h05:        size_s = SZ_BYTE;
      6'h06:        size_s = SZ_HALF;
      default:      legal_s = 1'b0;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign ok_s = legal_s && !((size_s == SZ_WORD && addr_r[1:0] != 2'b00) ||
                             (size_s == SZ_HALF && addr_r[0]));
`else
  assign ok_s = legal_s;
`endif

  // Effective byte addresses; word/halfword addresses are rounded down to their boundary
  always_comb begin
    a0_s = addr_r;
    if (size_s == SZ_WORD) begin
      a0_s = addr_r & 8'hFC;
    end else if (size_s == SZ_HALF) begin
      a0_s = addr_r & 8'hFE;
    end else begin
      a0_s = addr_r;
    end
    a1_s = a0_s + 8'd1;
    a2_s = a0_s + 8'd2;
    a3_s = a0_s + 8'd3;
  end

  // Big-endian read with zero/sign extension
  always_comb begin
    load_val_s = 32'h0;
    case (size_s)
      SZ_WORD: load_val_s = {mem_r[a0_s], mem_r[a1_s], mem_r[a2_s], mem_r[a3_s]};
      SZ_HALF: load_val_s = {{16{signed_s & mem_r[a0_s][7]}}, mem_r[a0_s], mem_r[a1_s]};
      default: load_val_s = {{24{signed_s & mem_r[a0_s][7]}}, mem_r[a0_s]};
    endcase
  end

  // Handshake FSM next-state and output decisions
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    dout_nxt_s  = dout_r;
    mfc_nxt_s   = mfc_r;
    err_nxt_s   = err_r;
    capture_s   = 1'b0;
    we_s        = 1'b0;
    case (state_r)
      IDLE: begin
        mfc_nxt_s = 1'b0;
        err_nxt_s = 1'b0;
        if (MFA) begin
          capture_s   = 1'b1;
          cnt_nxt_s   = WAIT_INIT;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          mfc_nxt_s   = 1'b1;
          err_nxt_s   = !ok_s;
          state_nxt_s = DONE;
          if (ok_s && is_load_s) begin
            dout_nxt_s = load_val_s;
          end else begin
            we_s = ok_s;
          end
        end
      end
      DONE: begin
        if (!MFA) begin
          mfc_nxt_s   = 1'b0;
          err_nxt_s   = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control, request latch and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      dout_r  <= 32'h0;
      mfc_r   <= 1'b0;
      err_r   <= 1'b0;
      op_r    <= 6'h0;
      addr_r  <= 8'h0;
      wdata_r <= 32'h0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dout_r  <= dout_nxt_s;
      mfc_r   <= mfc_nxt_s;
      err_r   <= err_nxt_s;
      if (capture_s) begin
        op_r    <= Opcode;
        addr_r  <= Address;
        wdata_r <= DataIn;
      end
    end
  end

  // Storage is never reset; a reset in the completing cycle suppresses the write
  always_ff @(posedge Clk) begin
    if (!Rst && we_s) begin
      case (size_s)
        SZ_WORD: begin
          mem_r[a0_s] <= wdata_r[31:24];
          mem_r[a1_s] <= wdata_r[23:16];
          mem_r[a2_s] <= wdata_r[15:8];
          mem_r[a3_s] <= wdata_r[7:0];
        end
        SZ_HALF: begin
          mem_r[a0_s] <= wdata_r[15:8];
          mem_r[a1_s] <= wdata_r[7:0];
        end
        default: mem_r[a0_s] <= wdata_r[7:0];
      endcase
    end
  end

  assign DataOut = dout_r;
  assign MFC     = mfc_r;
  assign Err     = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver queues expected responses, monitor checks each MFC rise.
module tb_mem_responder;

  localparam int W = 2;

  logic        Clk, Rst, MFA;
  logic [5:0]  Opcode;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MFC, Err;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic mfc_prev = 1'b0;

  mem_responder #(.WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Rst(Rst), .MFA(MFA), .Opcode(Opcode), .Address(Address),
    .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .Err(Err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: every rising MFC must match the oldest queued expectation
  always @(negedge Clk) begin
    if (MFC && !mfc_prev) begin
      if (sb_q.size() == 0) begin
        vectors = vectors + 1;
        miscompares = miscompares + 1;
        $display("FAIL unexpected_mfc: MFC rose at cycle %0d with no request outstanding", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        vectors = vectors + 3;
        if (DataOut !== e.dout) begin
          miscompares = miscompares + 1;
          $display("FAIL dataout: got %08h expected %08h", DataOut, e.dout);
        end
        if (Err !== e.err) begin
          miscompares = miscompares + 1;
          $display("FAIL err: got %0b expected %0b", Err, e.err);
        end
        if (cyc != e.cyc) begin
          miscompares = miscompares + 1;
          $display("FAIL latency: MFC rose at cycle %0d expected %0d", cyc, e.cyc);
        end
      end
    end
    mfc_prev <= MFC;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors = vectors + 1;
    if (got !== want) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %08h expected %08h", name, got, want);
    end
  endtask

  // One full four-phase transaction; hold keeps MFA high for extra cycles in DONE
  task automatic req(input logic [5:0] op, input logic [7:0] addr, input logic [31:0] data,
                     input logic [31:0] exp_dout, input logic exp_err, input int hold);
    exp_t e;
    int   n;
    @(negedge Clk);
    Opcode = op; Address = addr; DataIn = data; MFA = 1'b1;
    e.dout = exp_dout; e.err = exp_err; e.cyc = cyc + W + 2;
    sb_q.push_back(e);
    @(negedge Clk);
    Opcode = 6'($urandom); Address = 8'($urandom); DataIn = $urandom;
    n = 0;
    while (!MFC && n < 30) begin
      @(negedge Clk);
      n++;
    end
    if (!MFC) begin
      check("mfc_timeout", 32'(MFC), 32'd1);
      void'(sb_q.pop_front());
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      check("mfc_held", 32'(MFC), 32'd1);
    end
    MFA = 1'b0;
    @(negedge Clk);
    check("mfc_drop", 32'(MFC), 32'd0);
    check("err_drop", 32'(Err), 32'd0);
  endtask

  logic [31:0] held_v;

  initial begin
    Rst = 1'b1; MFA = 1'b0; Opcode = 6'h0; Address = 8'h0; DataIn = 32'h0;
    repeat (3) @(negedge Clk);
    check("reset_mfc", 32'(MFC), 32'd0);
    check("reset_err", 32'(Err), 32'd0);
    check("reset_dout", DataOut, 32'h0);
    Rst = 1'b0;

    req(6'h04, 8'h00, 32'h9C044012, 32'h00000000, 1'b0, 0);
    req(6'h08, 8'h00, 32'h0,        32'h9C044012, 1'b0, 0);
    req(6'h09, 8'h00, 32'h0,        32'hFFFFFF9C, 1'b0, 0);
    req(6'h01, 8'h00, 32'h0,        32'h0000009C, 1'b0, 0);
    req(6'h02, 8'h02, 32'h0,        32'h00004012, 1'b0, 0);
    req(6'h0A, 8'h00, 32'h0,        32'hFFFF9C04, 1'b0, 0);
    req(6'h05, 8'h01, 32'h123456AB, 32'hFFFF9C04, 1'b0, 0);
    req(6'h00, 8'h00, 32'h0,        32'h9CAB4012, 1'b0, 0);
    req(6'h04, 8'hFC, 32'h11223344, 32'h9CAB4012, 1'b0, 0);
    req(6'h06, 8'hFE, 32'h0000BEEF, 32'h9CAB4012, 1'b0, 0);
    req(6'h00, 8'hFC, 32'h0,        32'h1122BEEF, 1'b0, 0);
`ifdef MEM_ALIGN_CHECK_EN
    req(6'h00, 8'h02, 32'h0,        32'h1122BEEF, 1'b1, 0);
    req(6'h02, 8'h03, 32'h0,        32'h1122BEEF, 1'b1, 0);
`else
    req(6'h00, 8'h02, 32'h0,        32'h9CAB4012, 1'b0, 0);
    req(6'h02, 8'h03, 32'h0,        32'h00004012, 1'b0, 0);
`endif
    req(6'h01, 8'h01, 32'h0,        32'h000000AB, 1'b0, 4);

    req(6'h04, 8'h10, 32'h01020304, 32'h000000AB, 1'b0, 0);
    @(negedge Clk);
    Opcode = 6'h04; Address = 8'h10; DataIn = 32'h55AA55AA; MFA = 1'b1;
    @(negedge Clk);
    Rst = 1'b1; MFA = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    check("abort_mfc", 32'(MFC), 32'd0);
    repeat (6) @(negedge Clk);
    check("abort_mfc_late", 32'(MFC), 32'd0);
    check("abort_dout", DataOut, 32'h0);
    req(6'h08, 8'h10, 32'h0,        32'h01020304, 1'b0, 0);
    req(6'h3F, 8'h10, 32'hFFFFFFFF, 32'h01020304, 1'b1, 0);
    req(6'h00, 8'h10, 32'h0,        32'h01020304, 1'b0, 0);

    repeat (5) @(negedge Clk);
    held_v = 32'(sb_q.size());
    check("scoreboard_empty", held_v, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
